// File: rtl/mac_seq_if.sv
// Result handshake between the MAC sequencer and its consumer.
// The master presents result_val/result and the slave returns result_rdy.
interface mac_seq_if #(
    parameter int NBITS = 8
) ();
    logic             result_val;
    logic             result_rdy;
    logic [NBITS-1:0] result;

    modport master (
        output result_val,
        output result,
        input  result_rdy
    );

    modport slave (
        input  result_val,
        input  result,
        output result_rdy
    );
endinterface

// File: rtl/mac_seq.sv
// Sequencer for one MAC lane: buffers x/w, streams one dot product per
// start, and returns the MAC's ReLU'd output over a val/rdy handshake.
module mac_seq #(
    parameter int NBITS = 8,
    parameter int ABITS = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [ABITS-1:0] load_addr,
    input  logic [NBITS-1:0] load_x,
    input  logic [NBITS-1:0] load_w,
    input  logic             start,
    input  logic [ABITS:0]   len,
    output logic             busy,
    output logic             mac_rst,
    output logic             mac_istream_val,
    output logic             mac_ostream_req,
    output logic [NBITS-1:0] mac_x,
    output logic [NBITS-1:0] mac_w,
    input  logic [NBITS-1:0] mac_z,
    mac_seq_if.master        res
);
    localparam int DEPTH = 1 << ABITS;
    localparam logic [ABITS:0] LEN_MAX = {1'b1, {ABITS{1'b0}}};
    localparam logic [ABITS:0] LEN_ONE = {{ABITS{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, CLEAR, STREAM, DRAIN1, DRAIN2, REQ, CAPTURE, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] idx_q, idx_d;
    logic [ABITS:0]   len_q, len_d;
    logic [NBITS-1:0] result_q, result_d;

    logic [NBITS-1:0] x_buf_q [DEPTH];
    logic [NBITS-1:0] w_buf_q [DEPTH];

    logic len_ok;
    logic last;

    assign len_ok = (len != '0) && (len <= LEN_MAX);
    assign last   = ({1'b0, idx_q} == (len_q - LEN_ONE));

    // Buffers are deliberately left out of reset; only IDLE may write.
    always_ff @(posedge clk) begin
        if (load_en && state_q == IDLE) begin
            x_buf_q[load_addr] <= load_x;
            w_buf_q[load_addr] <= load_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        len_d           = len_q;
        result_d        = result_q;
        mac_rst         = rst;
        mac_istream_val = 1'b0;
        mac_ostream_req = 1'b0;
        mac_x           = '0;
        mac_w           = '0;
        unique case (state_q)
            IDLE: begin
                if (start && len_ok) begin
                    state_d = CLEAR;
                    len_d   = len;
                end
            end
            CLEAR: begin
                mac_rst = 1'b1;
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                mac_istream_val = 1'b1;
                mac_x           = x_buf_q[idx_q];
                mac_w           = w_buf_q[idx_q];
                idx_d           = idx_q + 1'b1;
                if (last) state_d = DRAIN1;
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: state_d = REQ;
            REQ: begin
                mac_ostream_req = 1'b1;
                state_d         = CAPTURE;
            end
            CAPTURE: begin
                result_d = mac_z;
                state_d  = DONE;
            end
            DONE: begin
                if (res.result_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy           = (state_q != IDLE);
    assign res.result_val = (state_q == DONE);
    assign res.result     = result_q;
endmodule
